// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP capture block.
package dvp_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ENTRY_W = 14;  // {SOF, EOL, DATA}
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    ACTIVE     = 2'd2
  } dvp_state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dvp_fifo.sv
// Single-clock synchronous FIFO; output shows the head entry, zero when empty.
module dvp_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: oversamples the camera bus in the CLK domain, frames
// pixels into {SOF, EOL, DATA} beats and queues them for a valid/ready sink.
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          VSYNC_POL  = 1'b1,
  parameter bit          HSYNC_POL  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DVP_PCLK,
  input  logic              DVP_VSYNC,
  input  logic              DVP_HSYNC,
  input  logic [DATA_W-1:0] DVP_DATA,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_SOF,
  output logic              PIX_EOL,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              OVERFLOW,
  output logic [CNT_W-1:0]  LINE_LEN,
  output logic [CNT_W-1:0]  FRAME_LINES
);

  dvp_state_e              state_q, state_d;
  logic [1:0]              pclk_ff_q, pclk_ff_d;
  logic [1:0]              vsync_ff_q, vsync_ff_d;
  logic [1:0]              hsync_ff_q, hsync_ff_d;
  logic [1:0][DATA_W-1:0]  data_ff_q, data_ff_d;
  logic                    pclk_prev_q, pclk_prev_d;
  logic                    vsync_prev_q, vsync_prev_d;
  logic [2:0]              fill_q, fill_d;
  logic [DATA_W-1:0]       stage_q, stage_d;
  logic                    sof_pending_q, sof_pending_d;
  logic                    overflow_q, overflow_d;
  cnt_t                    pix_cnt_q, pix_cnt_d;
  cnt_t                    line_cnt_q, line_cnt_d;
  cnt_t                    line_len_q, line_len_d;
  cnt_t                    frame_lines_q, frame_lines_d;

  logic                    sync_ok, pclk_event, vs_act, vs_prev_act, vs_rise, vs_fall, hs_act;
  logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]      push_entry, fifo_dout;

  // The synchronizers clear to 0 on reset, which may not be the true line
  // level; edges are only trusted once both the sync stage and the history
  // flop hold real samples, so a sync held active through reset is not
  // mistaken for a fresh edge.
  assign sync_ok     = fill_q[2];
  assign pclk_event  = sync_ok & pclk_ff_q[1] & ~pclk_prev_q;
  assign vs_act      = (vsync_ff_q[1] == VSYNC_POL);
  assign vs_prev_act = (vsync_prev_q == VSYNC_POL);
  assign vs_rise     = sync_ok & vs_act & ~vs_prev_act;
  assign vs_fall     = sync_ok & ~vs_act & vs_prev_act;
  assign hs_act      = (hsync_ff_q[1] == HSYNC_POL);
  assign fifo_pop    = PIX_VALID & PIX_READY;

  // Synchronizers, framing FSM, counters and FIFO push decision.
  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    sof_pending_d = sof_pending_q;
    overflow_d    = overflow_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    fifo_push     = 1'b0;
    push_entry    = {sof_pending_q, ~hs_act, stage_q};

    pclk_ff_d     = {pclk_ff_q[0], DVP_PCLK};
    vsync_ff_d    = {vsync_ff_q[0], DVP_VSYNC};
    hsync_ff_d    = {hsync_ff_q[0], DVP_HSYNC};
    data_ff_d[0]  = DVP_DATA;
    data_ff_d[1]  = data_ff_q[0];
    pclk_prev_d   = pclk_ff_q[1];
    vsync_prev_d  = vsync_ff_q[1];
    fill_d        = {fill_q[1:0], 1'b1};

    if (vs_fall) frame_lines_d = line_cnt_q;

    if (vs_rise) begin
      state_d       = WAIT_LINE;
      sof_pending_d = 1'b1;
      line_cnt_d    = '0;
      pix_cnt_d     = '0;
      stage_d       = '0;
    end else if (pclk_event) begin
      case (state_q)
        WAIT_LINE: begin
          if (hs_act) begin
            stage_d   = data_ff_q[1];
            pix_cnt_d = CNT_W'(1);
            state_d   = ACTIVE;
          end
        end
        ACTIVE: begin
          fifo_push = 1'b1;
          if (fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
            state_d    = WAIT_FRAME;
          end else begin
            sof_pending_d = 1'b0;
            if (hs_act) begin
              stage_d   = data_ff_q[1];
              pix_cnt_d = sat_inc(pix_cnt_q);
            end else begin
              line_len_d = pix_cnt_q;
              line_cnt_d = sat_inc(line_cnt_q);
              state_d    = WAIT_LINE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= WAIT_FRAME;
      pclk_ff_q     <= '0;
      vsync_ff_q    <= '0;
      hsync_ff_q    <= '0;
      data_ff_q     <= '0;
      pclk_prev_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      fill_q        <= '0;
      stage_q       <= '0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      state_q       <= state_d;
      pclk_ff_q     <= pclk_ff_d;
      vsync_ff_q    <= vsync_ff_d;
      hsync_ff_q    <= hsync_ff_d;
      data_ff_q     <= data_ff_d;
      pclk_prev_q   <= pclk_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      fill_q        <= fill_d;
      stage_q       <= stage_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  dvp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {PIX_SOF, PIX_EOL, PIX_DATA} = fifo_dout;
  assign PIX_VALID   = ~fifo_empty;
  assign OVERFLOW    = overflow_q;
  assign LINE_LEN    = line_len_q;
  assign FRAME_LINES = frame_lines_q;

endmodule

// File: doc/dvp_capture.md
DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: output FIFO entries, power of two, at least 4.
REQ-002 Parameter VSYNC_POL, default 1: active level of DVP_VSYNC.
REQ-003 Parameter HSYNC_POL, default 1: active level of DVP_HSYNC.
REQ-004 CLK  in  1  system clock; sole clock of the block.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 DVP_PCLK  in  1  camera pixel clock, sampled as data; frequency at most CLK/4.
REQ-007 DVP_VSYNC  in  1  frame sync.
REQ-008 DVP_HSYNC  in  1  line valid.
REQ-009 DVP_DATA  in  12  pixel sample.
REQ-010 PIX_DATA  out  12  captured pixel.
REQ-011 PIX_SOF  out  1  marks the first pixel of a frame.
REQ-012 PIX_EOL  out  1  marks the last pixel of a line.
REQ-013 PIX_VALID  out  1  output beat valid.
REQ-014 PIX_READY  in  1  downstream accept.
REQ-015 OVERFLOW  out  1  sticky: a pixel was dropped.
REQ-016 LINE_LEN  out  16  pixel count of the last completed line.
REQ-017 FRAME_LINES  out  16  line count of the last completed frame.

Function
REQ-018 All four DVP inputs SHALL pass through 2-flop synchronizers; every decision SHALL use synchronized values only.
REQ-019 A PCLK event SHALL be a 0->1 transition of synchronized DVP_PCLK; DVP_DATA and HSYNC SHALL be sampled in the same CLK cycle as that event.
REQ-020 The FSM SHALL have the states WAIT_FRAME, WAIT_LINE and ACTIVE; it SHALL leave reset in WAIT_FRAME.
REQ-021 From any state, an inactive->active edge of synchronized VSYNC SHALL enter WAIT_LINE, arm sof_pending, clear the line counter and discard any staged pixel.
REQ-022 WAIT_LINE: a PCLK event with HSYNC active SHALL load the pixel into the one-entry staging register and enter ACTIVE.
REQ-023 ACTIVE: a PCLK event with HSYNC active SHALL push the staged pixel with EOL=0 and stage the new pixel.
REQ-024 ACTIVE: a PCLK event with HSYNC inactive SHALL push the staged pixel with EOL=1, update LINE_LEN, increment the line counter and return to WAIT_LINE.
REQ-025 The first push after sof_pending is armed SHALL carry SOF=1; that push SHALL clear sof_pending.
REQ-026 A VSYNC active->inactive edge SHALL copy the line counter to FRAME_LINES.
REQ-027 The pixel counter SHALL saturate at 16'hFFFF; it SHALL not wrap.
REQ-028 FIFO entries SHALL be {SOF, EOL, DATA}, 14 bits wide.
REQ-029 PIX_VALID SHALL equal FIFO not empty.
REQ-030 A beat SHALL transfer when PIX_VALID and PIX_READY are both high.
REQ-031 The outputs SHALL be stable while PIX_VALID=1 and PIX_READY=0.
REQ-032 A push and a pop in the same cycle SHALL both complete when the FIFO is full.
REQ-033 A push into a full FIFO without a simultaneous pop SHALL drop the pixel, set OVERFLOW and force WAIT_FRAME.
REQ-034 After an overflow, no pixels SHALL be pushed until the next VSYNC edge.
REQ-035 Latency from a PCLK event to the appearance of the staged pixel at the FIFO output SHALL be at most 2 CLK cycles when the FIFO is empty.

Reset
REQ-036 While RST_N=0 at a CLK edge, the following SHALL clear: FIFO pointers, staging register, sof_pending, counters, synchronizers, OVERFLOW, LINE_LEN and FRAME_LINES.
REQ-037 While RST_N=0, the FSM SHALL go to WAIT_FRAME, PIX_VALID to 0 and PIX_SOF/PIX_EOL/PIX_DATA to 0.
REQ-038 Reset asserted mid-line SHALL discard the line; capture SHALL resume only at the next VSYNC active edge.

Structure
REQ-039 Package dvp_pkg SHALL hold the FSM state encoding, the 14-bit entry width and the 16-bit counter width.
REQ-040 The FIFO SHALL be the sub-module dvp_fifo (synchronous, single clock, parameterized depth and width); the FSM, synchronizers and counters SHALL stay in dvp_capture.

Verification
REQ-041 Frame of 2 lines x 4 pixels (0x001..0x008), PCLK=CLK/4, READY=1 -> 8 beats in order; SOF on 0x001, EOL on 0x004 and 0x008; LINE_LEN=4; FRAME_LINES=2 after VSYNC falls.
REQ-042 READY=0 for an entire 20-pixel line, FIFO_DEPTH=16 -> OVERFLOW=1, exactly 16 beats retained; no pushes until the next VSYNC; the next frame is captured normally with SOF.
REQ-043 READY toggled every cycle over a 10-pixel line -> all 10 values delivered in order; no duplicates; data held stable while stalled.
REQ-044 RST_N low for 1 cycle after pixel 3 of a line -> PIX_VALID=0 next cycle; the rest of the frame is ignored; the next VSYNC frame starts with SOF.
REQ-045 VSYNC_POL=0 and HSYNC_POL=0 with an inverted-sync stimulus -> same output as REQ-041.
REQ-046 1-pixel line -> a single beat with SOF=1 and EOL=1 together; LINE_LEN=1.
